instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Consumer-side partner of the program counter register; closes the PC loop.
- Reads the current PC value and issues a word fetch to instruction memory over a req/ack handshake.
- Queues fetched instructions, each tagged with its PC, for the decode stage.
- Drives the PC's next-value input every cycle: hold, +4, or redirect target.

Parameters:
- DEPTH, 4, instruction queue entries (power of 2, at least 2).
- RESET_PC, 32'h0000_0000, value driven on pc_next while rst is high.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_in  in  32  current PC value (PC register data_out).
- pc_next  out  32  next PC value (PC register data_in); the PC loads it every clock.
- imem_req  out  1  fetch request, registered.
- imem_addr  out  32  word-aligned fetch address, registered.
- imem_ack  in  1  memory completion pulse; valid only while imem_req=1.
- imem_rdata  in  32  instruction word; valid in the cycle imem_ack=1.
- redirect  in  1  branch/jump taken; flush and reload the PC.
- redirect_addr  in  32  target address for redirect.
- instr_valid  out  1  queue head valid.
- instr_out  out  32  queue head instruction.
- instr_pc  out  32  PC of the queue head instruction.
- instr_ready  in  1  decode accepts the head; a pop occurs when valid and ready are both 1.

Behaviour:
- Reset (async, immediate):
  - imem_req=0, imem_addr=0; queue empty; instr_valid=0, instr_out=0, instr_pc=0; state=IDLE.
  - pc_next=RESET_PC (combinational while rst=1).
- pc_next is combinational, in priority order:
  - redirect=1 -> redirect_addr.
  - Else acked fetch (state WAIT and imem_ack=1) -> pc_in+4, mod 2^32 (32'hFFFF_FFFC wraps to 0).
  - Else pc_in (hold).
- FSM states: IDLE, WAIT, DROP.
  - IDLE: if redirect=0 and (count < DEPTH) -> WAIT; set imem_req=1 and imem_addr={pc_in[31:2],2'b00}. pc_in[1:0] is ignored.
  - WAIT: imem_req and imem_addr are held stable until imem_ack.
    - imem_ack=1, redirect=0 -> push {pc_in, imem_rdata}; req=0; go to IDLE.
    - redirect=1 (with or without ack) -> flush queue. If ack is also 1, discard the data, req=0, go to IDLE. Otherwise go to DROP with req held at 1.
  - DROP: req stays high; on imem_ack discard the data, req=0, go to IDLE. A further redirect in DROP only updates pc_next; state stays DROP.
- One outstanding request at most. Minimum fetch period is 2 cycles (ack in WAIT, then re-issue from IDLE the next cycle).
- Queue ordering and handshake:
  - FIFO order; instr_valid=(count!=0); head outputs come directly from registers.
  - Push and pop in the same cycle leaves count unchanged.
  - Because of the IDLE space check, a push never occurs when the queue is full.
- Redirect is registered flush: the queue is empty the next cycle and instr_valid=0. Redirect beats a same-cycle pop and a same-cycle push.
- Redirect in IDLE: no issue that cycle. The PC loads the target, and the fetch issues the following cycle.
- Reset mid-transaction abandons the request (req falls asynchronously). Memory must tolerate a dropped req.

Test Plan:
- Reset then release, instr_ready=1, memory acks 1 cycle after req: pc_next=0 during reset; fetch addrs 0,4,8,C in order; instr_pc matches instr_out; PC advances by 4 per ack.
- instr_ready=0 with 6 fetches available: exactly DEPTH=4 pushes, then imem_req stays 0 and pc_in holds 0x10. Raise ready: pops resume and fetches resume at 0x10.
- Redirect to 0x400 while in WAIT with ack 3 cycles later: queue flushed next cycle, DROP until ack, acked data discarded, next fetch address=0x400.
- Redirect to 0x800 in the same cycle as imem_ack: data not pushed, pc_next=0x800, next fetch=0x800.
- pc_in=32'hFFFF_FFFC acked: pc_next=0. pc_in=0x0000_0103: imem_addr=0x100, instr_pc=0x103.
- Assert rst while in WAIT with 2 entries queued: imem_req=0 and instr_valid=0 asynchronously. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit
//  Purpose  : Closes the program-counter loop. Issues one word fetch at a
//             time to instruction memory (req/ack), queues the returned
//             instructions tagged with their PC for decode, and drives the
//             PC register's next value every cycle (hold / +4 / redirect).
//  Ports    : clk, rst            - clock, async active-high reset
//             pc_in / pc_next     - PC register data_out / data_in
//             imem_req/addr/ack/rdata - instruction memory handshake
//             redirect/_addr      - taken branch/jump, flushes the queue
//             instr_valid/out/pc/ready - decode-side queue head handshake
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    // Count needs one extra bit so that "full" (== DEPTH) is representable.
    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0]   C_ONE   = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_q_instr [DEPTH];
    logic [31:0]     r_q_pc    [DEPTH];

    logic            w_ack_wait;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_widx;

    // Entry 0 is always the head, so the decode outputs are plain registers.
    assign instr_valid = (r_count != '0);
    assign instr_out   = r_q_instr[0];
    assign instr_pc    = r_q_pc[0];

    // Only an ack in WAIT belongs to a live fetch; an ack in DROP is stale.
    assign w_ack_wait = (r_state == S_WAIT) && imem_ack;
    assign w_push     = w_ack_wait && !redirect;
    assign w_pop      = instr_valid && instr_ready;

    // The queue shifts toward the head on a pop, so a simultaneous push
    // lands one slot lower than the current tail.
    assign w_widx = w_pop ? (r_count - C_ONE) : r_count;

    always_comb begin
        pc_next = pc_in;
        if (rst) begin
            pc_next = RESET_PC;
        end else if (redirect) begin
            pc_next = redirect_addr;
        end else if (w_ack_wait) begin
            pc_next = pc_in + 32'd4;
        end
    end

    // Fetch sequencer: at most one outstanding request. A redirect while a
    // request is in flight cannot cancel it, so DROP waits for the ack and
    // throws the data away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!redirect && (r_count < C_DEPTH)) begin
                        r_state   <= S_WAIT;
                        imem_req  <= 1'b1;
                        imem_addr <= {pc_in[31:2], 2'b00};
                    end
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        r_state  <= S_IDLE;
                        imem_req <= 1'b0;
                    end else if (redirect) begin
                        r_state <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        r_state  <= S_IDLE;
                        imem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    // Instruction queue (shift-register FIFO). Redirect overrides both push
    // and pop by clearing the count; stale entry contents are harmless since
    // instr_valid is derived from the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_instr[i] <= '0;
                r_q_pc[i]    <= '0;
            end
        end else begin
            if (redirect) begin
                r_count <= '0;
            end else if (w_push && !w_pop) begin
                r_count <= r_count + C_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - C_ONE;
            end

            for (int i = 0; i < DEPTH - 1; i++) begin
                if (w_push && (w_widx == CW'(i))) begin
                    r_q_instr[i] <= imem_rdata;
                    r_q_pc[i]    <= pc_in;
                end else if (w_pop) begin
                    r_q_instr[i] <= r_q_instr[i+1];
                    r_q_pc[i]    <= r_q_pc[i+1];
                end
            end
            if (w_push && (w_widx == CW'(DEPTH - 1))) begin
                r_q_instr[DEPTH-1] <= imem_rdata;
                r_q_pc[DEPTH-1]    <= pc_in;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_unit
//  Purpose  : Self-checking bench for instr_fetch_unit. Models the PC
//             register and instruction memory, and keeps a transaction-level
//             reference (expected PC, expected queue contents, outstanding
//             fetch) derived from the fetch/queue/redirect rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_ready;

    int checks   = 0;
    int failures = 0;

    int          mem_lat = 1;
    int          age     = 0;
    logic [31:0] last_pc_next;

    // reference model state
    logic [31:0] m_q_pc [$];
    logic [31:0] m_q_ins[$];
    logic        m_out;
    logic        m_drop;
    logic [31:0] m_addr;
    logic [31:0] m_pc;

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_in        (pc_in),
        .pc_next      (pc_next),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .instr_valid  (instr_valid),
        .instr_out    (instr_out),
        .instr_pc     (instr_pc),
        .instr_ready  (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        m_q_pc.delete();
        m_q_ins.delete();
        m_out  = 1'b0;
        m_drop = 1'b0;
        m_addr = '0;
        m_pc   = RESET_PC;
        age    = 0;
    endtask

    // One clock: drive inputs, advance the reference model, clock the PC
    // register model. Called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic redir, input logic [31:0] raddr, input logic rdy);
        int          sz;
        logic [31:0] nxt;
        redirect      = redir;
        redirect_addr = raddr;
        instr_ready   = rdy;
        imem_rdata    = $urandom;
        if (imem_req && !rst) begin
            age++;
            imem_ack = (age >= mem_lat);
        end else begin
            age      = 0;
            imem_ack = 1'b0;
        end

        if (rst) begin
            model_clear();
        end else begin
            sz = m_q_pc.size();
            if (sz != 0 && rdy) begin
                void'(m_q_pc.pop_front());
                void'(m_q_ins.pop_front());
            end
            if (m_out && imem_ack) begin
                if (!redir && !m_drop) begin
                    m_q_pc.push_back(m_pc);
                    m_q_ins.push_back(imem_rdata);
                    m_pc = m_pc + 32'd4;
                end
                m_out  = 1'b0;
                m_drop = 1'b0;
            end else if (m_out && redir) begin
                m_drop = 1'b1;
            end else if (!m_out && !redir && sz < DEPTH) begin
                m_out  = 1'b1;
                m_addr = {m_pc[31:2], 2'b00};
            end
            if (redir) begin
                m_q_pc.delete();
                m_q_ins.delete();
                m_pc = raddr;
            end
        end

        @(negedge clk);
        nxt          = pc_next;
        last_pc_next = nxt;
        @(posedge clk);
        #1;
        pc_in = nxt;
        if (imem_ack) age = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        pc_in         = 32'hDEAD_BEE0;
        redirect      = 1'b1;
        redirect_addr = 32'h1234_5678;
        #1;
        checks++; if (pc_next !== RESET_PC) begin failures++; $display("FAIL reset_pc_next got %h expected %h", pc_next, RESET_PC); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got %b expected 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got %h expected 0", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b expected 0", instr_valid); end
        checks++; if (instr_out !== 32'h0 || instr_pc !== 32'h0) begin failures++; $display("FAIL reset_head got %h/%h expected 0/0", instr_out, instr_pc); end
        redirect = 1'b0;
        model_clear();
        apply_reset();
        checks++; if (pc_in !== RESET_PC) begin failures++; $display("FAIL reset_pc_loaded got %h expected %h", pc_in, RESET_PC); end
    endtask

    task automatic test_sequential();
        int   k    = 0;
        logic prev = 1'b0;
        apply_reset();
        mem_lat = 1;
        for (int c = 0; c < 20 && k < 4; c++) begin
            step(1'b0, 32'h0, 1'b1);
            if (imem_req && !prev) begin
                checks++; if (imem_addr !== 32'(k * 4)) begin failures++; $display("FAIL seq_addr%0d got %h expected %h", k, imem_addr, 32'(k * 4)); end
                k++;
            end
            prev = imem_req;
            checks++;
            if (instr_valid !== (m_q_pc.size() != 0)) begin
                failures++; $display("FAIL seq_valid got %b expected %b", instr_valid, m_q_pc.size() != 0);
            end else if (instr_valid && (instr_pc !== m_q_pc[0] || instr_out !== m_q_ins[0])) begin
                failures++; $display("FAIL seq_head got %h/%h expected %h/%h", instr_pc, instr_out, m_q_pc[0], m_q_ins[0]);
            end
            checks++; if (pc_in !== m_pc) begin failures++; $display("FAIL seq_pc got %h expected %h", pc_in, m_pc); end
        end
        checks++; if (k != 4) begin failures++; $display("FAIL seq_issue_count got %0d expected 4", k); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_head = 32'h0;
        logic        prev     = 1'b0;
        logic        seen     = 1'b0;
        apply_reset();
        mem_lat = 1;
        for (int c = 0; c < 20; c++) step(1'b0, 32'h0, 1'b0);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req_full got %b expected 0", imem_req); end
        checks++; if (pc_in !== 32'h10) begin failures++; $display("FAIL bp_pc_hold got %h expected 00000010", pc_in); end
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin failures++; $display("FAIL bp_head got %b/%h expected 1/0", instr_valid, instr_pc); end
        prev = imem_req;
        for (int c = 0; c < 14; c++) begin
            if (instr_valid) begin
                checks++;
                if (instr_pc !== exp_head || instr_out !== m_q_ins[0]) begin
                    failures++; $display("FAIL bp_pop got %h/%h expected %h/%h", instr_pc, instr_out, exp_head, m_q_ins[0]);
                end
                exp_head = exp_head + 32'd4;
            end
            step(1'b0, 32'h0, 1'b1);
            if (imem_req && !prev && !seen) begin
                seen = 1'b1;
                checks++; if (imem_addr !== 32'h10) begin failures++; $display("FAIL bp_resume_addr got %h expected 00000010", imem_addr); end
            end
            prev = imem_req;
        end
        checks++; if (!seen) begin failures++; $display("FAIL bp_resume got no fetch expected fetch at 00000010"); end
    endtask

    task automatic test_redirect_wait();
        apply_reset();
        mem_lat = 1;
        for (int c = 0; c < 20 && m_q_pc.size() < 2; c++) step(1'b0, 32'h0, 1'b0);
        mem_lat = 4;
        for (int c = 0; c < 5 && !imem_req; c++) step(1'b0, 32'h0, 1'b0);
        checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b1) begin failures++; $display("FAIL rw_setup got valid=%b req=%b expected 1/1", instr_valid, imem_req); end
        step(1'b1, 32'h400, 1'b0);
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rw_flush got %b expected 0", instr_valid); end
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rw_drop_req got %b expected 1", imem_req); end
        checks++; if (pc_in !== 32'h400) begin failures++; $display("FAIL rw_pc got %h expected 00000400", pc_in); end
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 32'h0, 1'b0);
            checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rw_discard got %b expected 0", instr_valid); end
            if (!imem_req) break;
        end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rw_ack_timeout got req=%b expected 0", imem_req); end
        step(1'b0, 32'h0, 1'b0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin failures++; $display("FAIL rw_refetch got %b/%h expected 1/00000400", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_ack();
        mem_lat = 1;
        for (int c = 0; c < 5 && !imem_req; c++) step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h800, 1'b0);
        checks++; if (last_pc_next !== 32'h800) begin failures++; $display("FAIL ra_pc_next got %h expected 00000800", last_pc_next); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL ra_no_push got %b expected 0", instr_valid); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL ra_req got %b expected 0", imem_req); end
        step(1'b0, 32'h0, 1'b0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h800) begin failures++; $display("FAIL ra_refetch got %b/%h expected 1/00000800", imem_req, imem_addr); end
    endtask

    task automatic test_wrap_unaligned();
        mem_lat = 1;
        for (int c = 0; c < 10 && imem_req; c++) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'hFFFF_FFFC, 1'b1);
        checks++; if (imem_req !== 1'b0 || pc_in !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wr_idle_redirect got %b/%h expected 0/fffffffc", imem_req, pc_in); end
        step(1'b0, 32'h0, 1'b1);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wr_issue got %b/%h expected 1/fffffffc", imem_req, imem_addr); end
        step(1'b0, 32'h0, 1'b1);
        checks++; if (last_pc_next !== 32'h0) begin failures++; $display("FAIL wr_wrap got %h expected 00000000", last_pc_next); end
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wr_head got %b/%h expected 1/fffffffc", instr_valid, instr_pc); end
        step(1'b1, 32'h103, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL ua_addr got %h expected 00000100", imem_addr); end
        step(1'b0, 32'h0, 1'b1);
        checks++; if (last_pc_next !== 32'h107) begin failures++; $display("FAIL ua_pc_next got %h expected 00000107", last_pc_next); end
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h103) begin failures++; $display("FAIL ua_instr_pc got %b/%h expected 1/00000103", instr_valid, instr_pc); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        mem_lat = 1;
        for (int c = 0; c < 20 && m_q_pc.size() < 2; c++) step(1'b0, 32'h0, 1'b0);
        mem_lat = 20;
        for (int c = 0; c < 5 && !imem_req; c++) step(1'b0, 32'h0, 1'b0);
        checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b1) begin failures++; $display("FAIL rm_setup got req=%b valid=%b expected 1/1", imem_req, instr_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rm_async_req got %b expected 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rm_async_valid got %b expected 0", instr_valid); end
        checks++; if (pc_next !== RESET_PC) begin failures++; $display("FAIL rm_pc_next got %h expected %h", pc_next, RESET_PC); end
        model_clear();
        step(1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        mem_lat = 1;
        step(1'b0, 32'h0, 1'b0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin failures++; $display("FAIL rm_restart got %b/%h expected 1/%h", imem_req, imem_addr, RESET_PC); end
    endtask

    task automatic test_random();
        logic        rd;
        logic [31:0] ra;
        apply_reset();
        for (int c = 0; c < 300; c++) begin
            if (!imem_req) mem_lat = $urandom_range(1, 3);
            rd = ($urandom_range(0, 9) == 0);
            ra = $urandom & 32'h0000_0FFF;
            step(rd, ra, ($urandom_range(0, 3) != 0));
            checks++; if (imem_req !== m_out) begin failures++; $display("FAIL rnd_req cyc=%0d got %b expected %b", c, imem_req, m_out); end
            checks++; if (m_out && imem_addr !== m_addr) begin failures++; $display("FAIL rnd_addr cyc=%0d got %h expected %h", c, imem_addr, m_addr); end
            checks++; if (pc_in !== m_pc) begin failures++; $display("FAIL rnd_pc cyc=%0d got %h expected %h", c, pc_in, m_pc); end
            checks++;
            if (instr_valid !== (m_q_pc.size() != 0)) begin
                failures++; $display("FAIL rnd_valid cyc=%0d got %b expected %b", c, instr_valid, m_q_pc.size() != 0);
            end else if (instr_valid && (instr_pc !== m_q_pc[0] || instr_out !== m_q_ins[0])) begin
                failures++; $display("FAIL rnd_head cyc=%0d got %h/%h expected %h/%h", c, instr_pc, instr_out, m_q_pc[0], m_q_ins[0]);
            end
        end
    endtask

    initial begin
        rst           = 1'b0;
        pc_in         = '0;
        imem_ack      = 1'b0;
        imem_rdata    = '0;
        redirect      = 1'b0;
        redirect_addr = '0;
        instr_ready   = 1'b0;
        last_pc_next  = '0;
        model_clear();
        #1;
        rst = 1'b1;
        #1;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_ack();
        test_wrap_unaligned();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
